// File: rtl/time_display_scan.sv
// Six-digit multiplexed HH.MM.SS display scanner.
// A prescaler steps through six digit slots. Each slot starts with a short
// anode-off blanking window. The time word is sampled once per frame so that
// a frame never shows a mix of old and new digits. In set mode the hour and
// minute digits blink. seg and an come straight from flops. They are
// computed from next-state values, so in any cycle they match that cycle's
// scan state.
module time_display_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK        = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] timeBus,
    input  logic        SW_cS,
    output logic [7:0]  seg,
    output logic [5:0]  an
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_V = CW'(BLANK);
    localparam logic [FW-1:0] FC_MAX  = FW'(BLINK_FRAMES - 1);

    // Seven-segment pattern for one decimal digit, active low {g..a}
    function automatic logic [6:0] digit_pattern(input logic [3:0] v);
        logic [6:0] p;
        case (v)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b0111111;
        endcase
        return p;
    endfunction

    // Pattern for the tens or units digit of a field; out-of-range fields show dashes
    function automatic logic [6:0] field_pattern(input logic [5:0] val,
                                                 input logic [5:0] limit,
                                                 input logic       tens);
        logic [6:0] p;
        if (val >= limit) begin
            p = 7'b0111111;
        end else if (tens) begin
            p = digit_pattern(4'(val / 6'd10));
        end else begin
            p = digit_pattern(4'(val % 6'd10));
        end
        return p;
    endfunction

    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    d_r, d_s;
    logic [4:0]    hours_r, hours_s;
    logic [5:0]    mins_r, mins_s;
    logic [5:0]    secs_r, secs_s;
    logic [FW-1:0] fc_r, fc_s;
    logic          blink_r, blink_s;
    logic [7:0]    seg_r, seg_s;
    logic [5:0]    an_r, an_s;
    logic          slot_end_s;
    logic          frame_end_s;
    logic [6:0]    digit_s;
    logic          dp_s;

    // Bits of the time word that carry no field
    logic unused_time_bits;
    assign unused_time_bits = ^{timeBus[23:21], timeBus[15:14], timeBus[7:6]};

    // Scan, snapshot and blink next-state logic
    always_comb begin
        slot_end_s  = (cnt_r == CNT_MAX);
        frame_end_s = slot_end_s && (d_r == 3'd5);

        if (slot_end_s) begin
            cnt_s = '0;
        end else begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end

        if (!slot_end_s) begin
            d_s = d_r;
        end else if (d_r == 3'd5) begin
            d_s = 3'd0;
        end else begin
            d_s = d_r + 3'd1;
        end

        if (frame_end_s) begin
            hours_s = timeBus[20:16];
            mins_s  = timeBus[13:8];
            secs_s  = timeBus[5:0];
        end else begin
            hours_s = hours_r;
            mins_s  = mins_r;
            secs_s  = secs_r;
        end

        if (!SW_cS) begin
            fc_s    = '0;
            blink_s = 1'b0;
        end else if (frame_end_s) begin
            if (fc_r == FC_MAX) begin
                fc_s    = '0;
                blink_s = ~blink_r;
            end else begin
                fc_s    = fc_r + {{(FW-1){1'b0}}, 1'b1};
                blink_s = blink_r;
            end
        end else begin
            fc_s    = fc_r;
            blink_s = blink_r;
        end
    end

    // Display decode of the next-cycle scan state
    always_comb begin
        case (d_s)
            3'd0:    digit_s = field_pattern({1'b0, hours_s}, 6'd24, 1'b1);
            3'd1:    digit_s = field_pattern({1'b0, hours_s}, 6'd24, 1'b0);
            3'd2:    digit_s = field_pattern(mins_s, 6'd60, 1'b1);
            3'd3:    digit_s = field_pattern(mins_s, 6'd60, 1'b0);
            3'd4:    digit_s = field_pattern(secs_s, 6'd60, 1'b1);
            3'd5:    digit_s = field_pattern(secs_s, 6'd60, 1'b0);
            default: digit_s = 7'b1111111;
        endcase

        if ((d_s == 3'd1) || (d_s == 3'd3)) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end

        if (cnt_s < BLANK_V) begin
            an_s  = 6'b111111;
            seg_s = 8'hFF;
        end else begin
            an_s = ~(6'b100000 >> d_s);
            if (blink_s && (d_s < 3'd4)) begin
                seg_s = 8'hFF;
            end else begin
                seg_s = {dp_s, digit_s};
            end
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r   <= '0;
            d_r     <= 3'd0;
            hours_r <= 5'd0;
            mins_r  <= 6'd0;
            secs_r  <= 6'd0;
            fc_r    <= '0;
            blink_r <= 1'b0;
            seg_r   <= 8'hFF;
            an_r    <= 6'b111111;
        end else begin
            cnt_r   <= cnt_s;
            d_r     <= d_s;
            hours_r <= hours_s;
            mins_r  <= mins_s;
            secs_r  <= secs_s;
            fc_r    <= fc_s;
            blink_r <= blink_s;
            seg_r   <= seg_s;
            an_r    <= an_s;
        end
    end

    assign seg = seg_r;
    assign an  = an_r;

endmodule

// File: tb/tb_time_display_scan.sv
// Randomized bench for time_display_scan with a cycle-count based reference model.
module tb_time_display_scan;

    localparam int SD = 4;
    localparam int BL = 1;
    localparam int BF = 2;
    localparam int FRAME = SD * 6;

    logic        clk;
    logic        rst;
    logic [23:0] timeBus;
    logic        SW_cS;
    logic [7:0]  seg;
    logic [5:0]  an;

    int total_cnt;
    int bad_cnt;

    // Reference model: edges since reset release, frame snapshot, set-mode frames
    int          n_edges;
    logic [23:0] snap_m;
    int          sw_frames;
    logic [6:0]  pat [10];

    time_display_scan #(.SCAN_DIV(SD), .BLANK(BL), .BLINK_FRAMES(BF)) dut (
        .clk     (clk),
        .rst     (rst),
        .timeBus (timeBus),
        .SW_cS   (SW_cS),
        .seg     (seg),
        .an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_digit(input int val, input int limit, input bit tens);
        if (val >= limit) return 7'b0111111;
        return tens ? pat[val / 10] : pat[val % 10];
    endfunction

    task automatic model_reset();
        n_edges   = 0;
        snap_m    = 24'd0;
        sw_frames = 0;
    endtask

    // Apply one rising edge to the model using the inputs the DUT just sampled
    task automatic model_edge();
        bit wrap;
        wrap = ((n_edges % FRAME) == FRAME - 1);
        if (wrap) snap_m = timeBus;
        if (!SW_cS) sw_frames = 0;
        else if (wrap) sw_frames++;
        n_edges++;
    endtask

    task automatic check_outputs();
        int slot, dd, hh, mm, ss;
        logic [5:0] exp_an;
        logic [7:0] exp_seg;
        logic [6:0] dig;
        bit blink;
        slot  = n_edges % SD;
        dd    = (n_edges / SD) % 6;
        hh    = int'(snap_m[20:16]);
        mm    = int'(snap_m[13:8]);
        ss    = int'(snap_m[5:0]);
        blink = ((sw_frames / BF) % 2) == 1;
        case (dd)
            0:       dig = model_digit(hh, 24, 1'b1);
            1:       dig = model_digit(hh, 24, 1'b0);
            2:       dig = model_digit(mm, 60, 1'b1);
            3:       dig = model_digit(mm, 60, 1'b0);
            4:       dig = model_digit(ss, 60, 1'b1);
            default: dig = model_digit(ss, 60, 1'b0);
        endcase
        if (slot < BL) begin
            check_val("an_blank", {10'd0, an}, 16'h003F);
        end else begin
            exp_an = 6'h3F & ~(6'd1 << (5 - dd));
            if (blink && dd < 4) exp_seg = 8'hFF;
            else exp_seg = {(dd == 1 || dd == 3) ? 1'b0 : 1'b1, dig};
            check_val("an", {10'd0, an}, {10'd0, exp_an});
            check_val("seg", {8'd0, seg}, {8'd0, exp_seg});
        end
    endtask

    function automatic logic [23:0] rand_time();
        int h, m, s;
        h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 23);
        m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59);
        s = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 59);
        return {3'($urandom), 5'(h), 2'($urandom), 6'(m), 2'($urandom), 6'(s)};
    endfunction

    // One checked cycle: compare at negedge, optionally perturb inputs, advance model
    task automatic step(input bit randomize_in);
        check_outputs();
        if (randomize_in) begin
            if ($urandom_range(0, 15) == 0) timeBus = rand_time();
            if ($urandom_range(0, 199) == 0) SW_cS = ~SW_cS;
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        total_cnt = 0;
        bad_cnt   = 0;
        rst       = 1'b0;
        SW_cS     = 1'b0;
        timeBus   = {3'd0, 5'd13, 2'd0, 6'd7, 2'd0, 6'd59};
        model_reset();

        repeat (3) @(negedge clk);
        check_val("reset_an", {10'd0, an}, 16'h003F);
        check_val("reset_seg", {8'd0, seg}, 16'h00FF);
        rst = 1'b1;

        // Held 13:07:59 from reset: frame 0 shows zeros, frame 1 the time
        repeat (2 * FRAME + 5) step(1'b0);

        // Out-of-range hours and minutes
        timeBus = {3'd0, 5'd24, 2'd0, 6'd60, 2'd0, 6'd5};
        repeat (2 * FRAME) step(1'b0);

        // Set mode held long enough for several blink periods, then dropped mid-blank
        SW_cS = 1'b1;
        repeat (6 * FRAME) step(1'b0);
        while ((n_edges % SD) != 0) step(1'b0);
        SW_cS = 1'b0;
        repeat (FRAME) step(1'b0);

        // Randomized time words and set-mode toggles
        repeat (3000) step(1'b1);

        // Asynchronous reset mid-slot in digit 3
        begin
            int guard;
            guard = 0;
            while (!(((n_edges / SD) % 6) == 3 && (n_edges % SD) == 2) && guard < 100) begin
                step(1'b1);
                guard++;
            end
            check_val("reach_d3", 16'(guard < 100), 16'd1);
        end
        #2 rst = 1'b0;
        #1;
        check_val("midrst_an", {10'd0, an}, 16'h003F);
        check_val("midrst_seg", {8'd0, seg}, 16'h00FF);
        model_reset();
        @(negedge clk);
        check_val("midrst_hold_an", {10'd0, an}, 16'h003F);
        rst = 1'b1;
        repeat (2 * FRAME) step(1'b1);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot; legal range >= 2.
REQ-002 SHALL have parameter BLANK, default 2: anode-off cycles at the start of each slot; legal range 0 <= BLANK < SCAN_DIV.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64: full frames per blink half-period; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port timeBus, input, 24 bits: time word; hours = [20:16], minutes = [13:8], seconds = [5:0]; all other bits ignored.
REQ-007 SHALL have port SW_cS, input, 1 bit: set-mode indicator; high enables blinking.
REQ-008 SHALL have port seg, output, 8 bits: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-009 SHALL have port an, output, 6 bits: active-low digit enables; an[5] is the leftmost digit.

Function
REQ-010 SHALL keep a prescaler cnt counting 0..SCAN_DIV-1 and wrapping to 0 at SCAN_DIV-1.
REQ-011 SHALL advance digit index d (0..5, wrap 5->0) on the edge where cnt == SCAN_DIV-1.
REQ-012 SHALL map d to digits and anodes: d0 hours tens/an[5], d1 hours units/an[4], d2 minutes tens/an[3], d3 minutes units/an[2], d4 seconds tens/an[1], d5 seconds units/an[0].
REQ-013 SHALL load a snapshot of the three fields from timeBus only on the edge where cnt == SCAN_DIV-1 and d == 5, so every displayed frame is tear-free; timeBus changes at any other time SHALL have no visible effect until the next frame.
REQ-014 SHALL drive seg and an from flops; their value in any cycle SHALL equal the decode of that cycle's cnt, d, snapshot and blink phase.
REQ-015 SHALL hold an = 6'b111111 while cnt < BLANK; otherwise only the bit for d SHALL be low.
REQ-016 SHALL split each field into decimal tens and units; valid ranges are hours 0..23, minutes 0..59, seconds 0..59.
REQ-017 SHALL display both digits of an out-of-range field as a dash, seg[6:0] = 7'b0111111.
REQ-018 SHALL use seg[6:0] patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL light dp (seg[7] = 0) on d1 and d3 only; seg[7] = 1 on all other digits.
REQ-020 SHALL count completed frames (d wraps 5->0) and toggle blink phase each BLINK_FRAMES frames while SW_cS = 1.
REQ-021 SHALL hold the frame counter and blink phase at 0 while SW_cS = 0; a transition of SW_cS to 0 SHALL clear both on the next edge.
REQ-022 SHALL force seg = 8'hFF on d0..d3 when SW_cS = 1 and blink phase = 1; anodes SHALL behave per REQ-015; d4 and d5 never blink.

Reset
REQ-023 SHALL clear cnt, d, snapshot, frame counter and blink phase to 0 asynchronously whenever rst = 0.
REQ-024 SHALL drive an = 6'b111111 and seg = 8'hFF while rst = 0.
REQ-025 SHALL start counting on the first rising edge after rst deasserts; the first frame shows 00.00.00 with snapshot = 0.
REQ-026 SHALL return to the REQ-023 state immediately if rst asserts mid-slot or mid-frame, with no partial snapshot retained.

Verification (SCAN_DIV=4, BLANK=1, BLINK_FRAMES=2)
REQ-027 Release reset with timeBus = 0 -> cycle 0: an = 111111; cycles 1-3: an = 011111, seg = 8'b11000000; d advances after 4 cycles.
REQ-028 Hold timeBus with hours = 13, minutes = 7, seconds = 59 from reset -> first frame shows 00.00.00; second frame shows d0..d5 seg[6:0] = 1,3,0,7,5,9 with dp lit on d1 and d3.
REQ-029 Change timeBus while d = 2 -> display unchanged until the frame following the next d 5->0 wrap.
REQ-030 Apply hours = 24, minutes = 60, seconds = 5 -> d0..d3 show dash, d4/d5 show 0 and 5.
REQ-031 Hold SW_cS = 1 -> d0..d3 seg = 8'hFF for alternate 2-frame periods while d4/d5 keep their digits; drop SW_cS mid-blank -> digits return after the next edge.
REQ-032 Assert rst mid-slot with d = 3 -> an = 111111 and seg = 8'hFF immediately; after release, behaviour per REQ-027.
